fingerclip_model: RTL and testbench

Synthesizable behavioural model of a finger-clip photoplethysmography (PPG) sensor and its analog front-end. It generates a periodic heartbeat pulse riding on a large DC level. It subtracts a programmable DC compensation term, applies a programmable gain (PGA), and saturates the result to an 8-bit sample `Vppg`. It stands in for the optical sensor and AFE when verifying the pulse-oximetry control loop, which drives `DC_Comp` and `PGA_Gain`.

---
 rtl/fingerclip_model.sv | 61 ++++++
 tb/tb_fingerclip_model.sv | 107 ++++++++++
 2 files changed

// File: rtl/fingerclip_model.sv
// fingerclip_model: PPG sensor + AFE model with DC compensation, PGA gain and 8-bit saturation
module fingerclip_model #(
    parameter int CLK_DIV     = 1,
    parameter int BEAT_PERIOD = 100,
    parameter int RISE_LEN    = 20,
    parameter int RISE_STEP   = 2,
    parameter int FALL_STEP   = 1,
    parameter int DC_LEVEL    = 600,
    parameter int DC_STEP     = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [0:6] DC_Comp,
    input  logic [0:3] PGA_Gain,
    output logic [0:7] Vppg
);
    localparam int AC_PEAK = RISE_STEP * RISE_LEN;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PW = (BEAT_PERIOD > 1) ? $clog2(BEAT_PERIOD) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PH_MAX = PW'(BEAT_PERIOD - 1);

    logic [DW-1:0] div_q, div_d;
    logic [PW-1:0] ph_q, ph_d;
    logic [7:0] vppg_q, vppg_d;
    logic strobe;
    logic signed [31:0] p, fall, pulse, diff, amp;

    // Sample datapath: pulse shape, DC subtraction with clamp at 0, gain, final saturation.
    // 32-bit signed arithmetic keeps every intermediate exact, so only the last stage saturates.
    always_comb begin
        p     = $signed(32'(ph_q));
        fall  = AC_PEAK - FALL_STEP * (p - RISE_LEN);
        pulse = (p <= RISE_LEN) ? RISE_STEP * p : ((fall > 0) ? fall : 32'sd0);
        diff  = DC_LEVEL + pulse - $signed(32'(DC_Comp)) * DC_STEP;
        amp   = ((diff > 0) ? diff : 32'sd0) * ($signed(32'(PGA_Gain)) + 32'sd1);
    end

    // Divider, phase and output next-state; everything except div advances only on the strobe.
    always_comb begin
        strobe = (div_q == DIV_MAX);
        div_d  = strobe ? '0 : div_q + DW'(1);
        ph_d   = strobe ? ((ph_q == PH_MAX) ? '0 : ph_q + PW'(1)) : ph_q;
        vppg_d = strobe ? ((amp > 32'sd255) ? 8'd255 : amp[7:0]) : vppg_q;
    end

    // State registers with immediate (asynchronous) clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            ph_q   <= '0;
            vppg_q <= '0;
        end else begin
            div_q  <= div_d;
            ph_q   <= ph_d;
            vppg_q <= vppg_d;
        end
    end

    assign Vppg = vppg_q;
endmodule

// File: tb/tb_fingerclip_model.sv
// tb_fingerclip_model: directed + randomized checks of fingerclip_model against an arithmetic reference
module tb_fingerclip_model;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [0:6] dc = '0;
    logic [0:3] g = '0;
    logic [0:7] v1, v3;
    int n_tot = 0, n_pass = 0, n_fail = 0;
    int ph1 = 0, ph3 = 0, e3 = 0, exp3 = 0;

    always #5 clk = ~clk;

    fingerclip_model dut1 (.clk(clk), .rst_n(rst_n), .DC_Comp(dc), .PGA_Gain(g), .Vppg(v1));
    fingerclip_model #(.CLK_DIV(3)) dut3 (.clk(clk), .rst_n(rst_n), .DC_Comp(dc), .PGA_Gain(g), .Vppg(v3));

    function automatic int ref_val(int p, int c, int k);
        int pl, d;
        if (p <= 20) pl = 2 * p;
        else pl = 40 - (p - 20);
        if (pl < 0) pl = 0;
        d = 600 + pl - 15 * c;
        if (d < 0) d = 0;
        d = d * (k + 1);
        return (d > 255) ? 255 : d;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input int expv);
        n_tot++;
        assert (obs === 8'(expv)) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: Vppg=%0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        #1;
        e3++;
        if (e3 % 3 == 0) begin
            exp3 = ref_val(ph3, int'(dc), int'(g));
            ph3 = (ph3 + 1) % 100;
        end
        chk({tag, "_div1"}, v1, ref_val(ph1, int'(dc), int'(g)));
        ph1 = (ph1 + 1) % 100;
        chk({tag, "_div3"}, v3, exp3);
    endtask

    task automatic restart_model();
        ph1 = 0;
        ph3 = 0;
        e3 = 0;
        exp3 = 0;
    endtask

    initial begin
        #12;
        chk("reset_div1", v1, 0);
        chk("reset_div3", v3, 0);
        @(negedge clk);
        rst_n = 1'b1;
        restart_model();
        dc = 7'd0; g = 4'd0;
        for (int i = 0; i < 100; i++) step("nocomp");
        dc = 7'd40;
        for (int i = 0; i < 100; i++) step("comp40_g0");
        g = 4'd3;
        for (int i = 0; i < 100; i++) step("comp40_g3");
        g = 4'd6;
        for (int i = 0; i < 100; i++) step("comp40_g6");
        g = 4'd15;
        for (int i = 0; i < 100; i++) step("comp40_g15");
        dc = 7'd127;
        for (int i = 0; i < 100; i++) begin
            g = 4'($urandom_range(0, 15));
            step("overcomp");
        end
        dc = 7'd40; g = 4'd6;
        while (ph1 != 11) step("prereset");
        chk("prereset_peak", v1, 140);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset_div1", v1, 0);
        chk("async_reset_div3", v3, 0);
        @(negedge clk);
        rst_n = 1'b1;
        restart_model();
        step("phase0_after_reset");
        dc = 7'd0; g = 4'd0;
        for (int i = 0; i <= 40; i++) begin
            dc = 7'(i);
            step("ramp_dc");
        end
        for (int i = 0; i <= 15; i++) begin
            g = 4'(i);
            step("ramp_gain");
        end
        for (int i = 0; i < 400; i++) begin
            dc = 7'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 127) : $urandom_range(25, 60));
            g = 4'($urandom_range(0, 15));
            step("random");
        end
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
